// File: rtl/l2_port_arbiter_if.sv
// Line-transaction port shared by the cache requesters and physical memory.
// master = side that issues read/write, slave = side that answers with resp/rdata.
interface l2_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LINE_W-1:0] wdata;
  logic              resp;
  logic [LINE_W-1:0] rdata;

  modport master (output read, write, address, wdata, input resp, rdata);
  modport slave  (input read, write, address, wdata, output resp, rdata);
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares one pmem line port between the I-cache and D-cache.
// Fixed D-over-I priority with a starvation limit guaranteeing I progress.
// pmem request outputs are registered; x_resp is pmem_resp gated by the grant.
// Optional macro L2_ARB_STATS_EN adds grant and wait-cycle counters.
module l2_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned LINE_W       = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  l2_port_arbiter_if.slave  i_port,
  l2_port_arbiter_if.slave  d_port,
  l2_port_arbiter_if.master pmem_port
`ifdef L2_ARB_STATS_EN
  ,
  output logic [31:0]       stat_i_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_wait_cycles
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_starve_cnt;
  logic [CNT_W-1:0]    w_starve_nxt;
  logic                r_pmem_read;
  logic                w_pmem_read_nxt;
  logic                r_pmem_write;
  logic                w_pmem_write_nxt;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [ADDR_W-1:0]   w_pmem_address_nxt;
  logic [LINE_W-1:0]   r_pmem_wdata;
  logic [LINE_W-1:0]   w_pmem_wdata_nxt;

  logic                w_i_pend;
  logic                w_d_pend;
  logic                w_grant_d;
  logic                w_grant_i;

  assign w_i_pend  = i_port.read | i_port.write;
  assign w_d_pend  = d_port.read | d_port.write;
  // D wins unless I has already been passed over STARVE_LIMIT times in a row.
  assign w_grant_d = (r_state == ST_IDLE) && w_d_pend &&
                     (!w_i_pend || (r_starve_cnt < CNT_W'(STARVE_LIMIT)));
  assign w_grant_i = (r_state == ST_IDLE) && !w_grant_d && w_i_pend;

  // State and registered pmem request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_starve_cnt   <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_starve_cnt   <= w_starve_nxt;
      r_pmem_read    <= w_pmem_read_nxt;
      r_pmem_write   <= w_pmem_write_nxt;
      r_pmem_address <= w_pmem_address_nxt;
      r_pmem_wdata   <= w_pmem_wdata_nxt;
    end
  end

  // Arbitration in IDLE; hold the request until pmem_resp while granted
  always_comb begin
    w_state_nxt        = r_state;
    w_starve_nxt       = r_starve_cnt;
    w_pmem_read_nxt    = r_pmem_read;
    w_pmem_write_nxt   = r_pmem_write;
    w_pmem_address_nxt = r_pmem_address;
    w_pmem_wdata_nxt   = r_pmem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt        = ST_GRANT_D;
          w_starve_nxt       = !w_i_pend ? '0 :
                               (r_starve_cnt == {CNT_W{1'b1}}) ? r_starve_cnt :
                               r_starve_cnt + CNT_W'(1);
          w_pmem_write_nxt   = d_port.write;
          w_pmem_read_nxt    = d_port.read & ~d_port.write;
          w_pmem_address_nxt = d_port.address;
          w_pmem_wdata_nxt   = d_port.wdata;
        end else if (w_grant_i) begin
          w_state_nxt        = ST_GRANT_I;
          w_starve_nxt       = '0;
          w_pmem_write_nxt   = i_port.write;
          w_pmem_read_nxt    = i_port.read & ~i_port.write;
          w_pmem_address_nxt = i_port.address;
          w_pmem_wdata_nxt   = i_port.wdata;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (pmem_port.resp) begin
          w_state_nxt      = ST_IDLE;
          w_pmem_read_nxt  = 1'b0;
          w_pmem_write_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_pmem_read_nxt  = 1'b0;
        w_pmem_write_nxt = 1'b0;
      end
    endcase
  end

  assign pmem_port.read    = r_pmem_read;
  assign pmem_port.write   = r_pmem_write;
  assign pmem_port.address = r_pmem_address;
  assign pmem_port.wdata   = r_pmem_wdata;

  // Completion only reaches the granted requester; read data is broadcast.
  assign i_port.resp  = pmem_port.resp & (r_state == ST_GRANT_I);
  assign d_port.resp  = pmem_port.resp & (r_state == ST_GRANT_D);
  assign i_port.rdata = pmem_port.rdata;
  assign d_port.rdata = pmem_port.rdata;

`ifdef L2_ARB_STATS_EN
  logic [31:0] r_stat_i;
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_w;
  logic        w_wait;

  assign w_wait = ((r_state == ST_IDLE)    && w_d_pend && w_i_pend) ||
                  ((r_state == ST_GRANT_I) && w_d_pend) ||
                  ((r_state == ST_GRANT_D) && w_i_pend);

  // Free-running wrap-around statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
      r_stat_w <= '0;
    end else begin
      if (w_grant_i) r_stat_i <= r_stat_i + 32'd1;
      if (w_grant_d) r_stat_d <= r_stat_d + 32'd1;
      if (w_wait)    r_stat_w <= r_stat_w + 32'd1;
    end
  end

  assign stat_i_grants    = r_stat_i;
  assign stat_d_grants    = r_stat_d;
  assign stat_wait_cycles = r_stat_w;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: table of request vectors plus hand-written
// starvation, mid-grant address change, reset-abort and stray-resp sequences.
// Expected pmem transactions are queued when requests are driven and popped
// when the arbiter presents a grant on pmem.
module tb_l2_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic clk;
  logic rst_n;

  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) i_bus ();
  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) d_bus ();
  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) p_bus ();

`ifdef L2_ARB_STATS_EN
  logic [31:0] st_i;
  logic [31:0] st_d;
  logic [31:0] st_w;
`endif

  l2_port_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_port(i_bus),
    .d_port(d_bus),
    .pmem_port(p_bus)
`ifdef L2_ARB_STATS_EN
    ,
    .stat_i_grants(st_i),
    .stat_d_grants(st_d),
    .stat_wait_cycles(st_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [255:0] wdata;
  } exp_t;

  typedef struct {
    bit          d_rd;
    bit          d_wr;
    bit          i_rd;
    bit          i_wr;
    logic [31:0] d_addr;
    logic [31:0] i_addr;
    int          lat;
    bit          d_first;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   total;
  int   bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic exp_t mk_exp(input bit is_d, input bit rd, input bit wr,
                                  input logic [31:0] addr, input logic [255:0] wd);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = wr;
    e.rd    = rd & ~wr;
    e.addr  = addr;
    e.wdata = wd;
    return e;
  endfunction

  task automatic drop(input bit is_d);
    if (is_d) begin
      d_bus.read  = 1'b0;
      d_bus.write = 1'b0;
    end else begin
      i_bus.read  = 1'b0;
      i_bus.write = 1'b0;
    end
  endtask

  // Called #1 after the edge where the grant must already be visible on pmem.
  task automatic serve(input int lat, input bit keep);
    exp_t         e;
    logic [255:0] rd;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got grant with no queued expectation");
      return;
    end
    e = sb.pop_front();
    chk("grant_strobes", 256'({p_bus.read, p_bus.write}), 256'({e.rd, e.wr}));
    chk("grant_addr", 256'(p_bus.address), 256'(e.addr));
    chk("grant_wdata", p_bus.wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      tick();
      chk("hold_strobes", 256'({p_bus.read, p_bus.write}), 256'({e.rd, e.wr}));
      chk("hold_addr", 256'(p_bus.address), 256'(e.addr));
      chk("early_resp", 256'({i_bus.resp, d_bus.resp}), 256'(0));
    end
    tick();
    rd          = rnd256();
    p_bus.resp  = 1'b1;
    p_bus.rdata = rd;
    #1;
    chk("d_resp", 256'(d_bus.resp), 256'(e.is_d));
    chk("i_resp", 256'(i_bus.resp), 256'(!e.is_d));
    chk("rdata", e.is_d ? d_bus.rdata : i_bus.rdata, rd);
    tick();
    p_bus.resp = 1'b0;
    if (!keep) drop(e.is_d);
    chk("bubble_strobes", 256'({p_bus.read, p_bus.write}), 256'(0));
    chk("bubble_resp", 256'({i_bus.resp, d_bus.resp}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         t;
    logic [255:0] dw;
    logic [255:0] iw;
    int           n;
    total = 0;
    bad   = 0;

    vecs[0] = '{d_rd:1, d_wr:0, i_rd:0, i_wr:0, d_addr:32'h0000_1000, i_addr:32'h0, lat:5, d_first:1};
    vecs[1] = '{d_rd:0, d_wr:1, i_rd:1, i_wr:0, d_addr:32'h80, i_addr:32'h40, lat:3, d_first:1};
    vecs[2] = '{d_rd:0, d_wr:0, i_rd:1, i_wr:0, d_addr:32'h0, i_addr:32'h200, lat:1, d_first:0};
    vecs[3] = '{d_rd:0, d_wr:1, i_rd:0, i_wr:0, d_addr:32'h300, i_addr:32'h0, lat:2, d_first:1};
    vecs[4] = '{d_rd:1, d_wr:0, i_rd:1, i_wr:0, d_addr:32'h600, i_addr:32'h500, lat:1, d_first:1};
    vecs[5] = '{d_rd:0, d_wr:0, i_rd:0, i_wr:1, d_addr:32'h0, i_addr:32'h700, lat:2, d_first:0};
    vecs[6] = '{d_rd:1, d_wr:1, i_rd:0, i_wr:0, d_addr:32'hDEAD_BEC0, i_addr:32'h0, lat:2, d_first:1};

    rst_n         = 1'b0;
    i_bus.read    = 1'b0;
    i_bus.write   = 1'b0;
    i_bus.address = '0;
    i_bus.wdata   = '0;
    d_bus.read    = 1'b0;
    d_bus.write   = 1'b0;
    d_bus.address = '0;
    d_bus.wdata   = '0;
    p_bus.resp    = 1'b0;
    p_bus.rdata   = '0;
    repeat (3) tick();

    chk("rst_strobes", 256'({p_bus.read, p_bus.write}), 256'(0));
    chk("rst_addr", 256'(p_bus.address), 256'(0));
    chk("rst_wdata", p_bus.wdata, 256'(0));
    chk("rst_resp", 256'({i_bus.resp, d_bus.resp}), 256'(0));
`ifdef L2_ARB_STATS_EN
    chk("rst_stats", 256'({st_i, st_d, st_w}), 256'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Table-driven request vectors
    for (int v = 0; v < 7; v++) begin
      t  = vecs[v];
      dw = rnd256();
      iw = rnd256();
      d_bus.read    = t.d_rd;
      d_bus.write   = t.d_wr;
      d_bus.address = t.d_addr;
      d_bus.wdata   = dw;
      i_bus.read    = t.i_rd;
      i_bus.write   = t.i_wr;
      i_bus.address = t.i_addr;
      i_bus.wdata   = iw;
      if (t.d_first) begin
        if (t.d_rd | t.d_wr) sb.push_back(mk_exp(1'b1, t.d_rd, t.d_wr, t.d_addr, dw));
        if (t.i_rd | t.i_wr) sb.push_back(mk_exp(1'b0, t.i_rd, t.i_wr, t.i_addr, iw));
      end else begin
        if (t.i_rd | t.i_wr) sb.push_back(mk_exp(1'b0, t.i_rd, t.i_wr, t.i_addr, iw));
        if (t.d_rd | t.d_wr) sb.push_back(mk_exp(1'b1, t.d_rd, t.d_wr, t.d_addr, dw));
      end
      n = int'(t.d_rd | t.d_wr) + int'(t.i_rd | t.i_wr);
      tick();
      for (int g = 0; g < n; g++) begin
        if (g > 0) tick();
        serve(t.lat, 1'b0);
      end
      tick();
    end

    // Requester changes its address while granted
    iw            = rnd256();
    i_bus.read    = 1'b1;
    i_bus.address = 32'h40;
    i_bus.wdata   = iw;
    sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'h40, iw));
    tick();
    i_bus.address = 32'h99;
    serve(4, 1'b0);
    tick();

    // D re-requests continuously while I waits: D,D,D,D,I,D
    dw = rnd256();
    iw = rnd256();
    d_bus.read    = 1'b1;
    d_bus.address = 32'hA00;
    d_bus.wdata   = dw;
    i_bus.read    = 1'b1;
    i_bus.address = 32'hB00;
    i_bus.wdata   = iw;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) sb.push_back(mk_exp(1'b0, 1'b1, 1'b0, 32'hB00, iw));
      else        sb.push_back(mk_exp(1'b1, 1'b1, 1'b0, 32'hA00, dw));
    end
    tick();
    for (int g = 0; g < 6; g++) begin
      if (g > 0) tick();
      serve(1, 1'b1);
    end
    drop(1'b1);
    drop(1'b0);
    tick();
    tick();

    // Reset during GRANT_D abandons the transaction
    d_bus.read    = 1'b1;
    d_bus.address = 32'h1234;
    d_bus.wdata   = rnd256();
    tick();
    chk("pre_rst_read", 256'(p_bus.read), 256'(1));
    tick();
    rst_n      = 1'b0;
    p_bus.resp = 1'b1;
    #1;
    chk("mid_rst_strobes", 256'({p_bus.read, p_bus.write}), 256'(0));
    chk("mid_rst_addr", 256'(p_bus.address), 256'(0));
    chk("mid_rst_resp", 256'({i_bus.resp, d_bus.resp}), 256'(0));
    drop(1'b1);
    p_bus.resp = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_strobes", 256'({p_bus.read, p_bus.write}), 256'(0));

    // Stray pmem_resp in IDLE produces nothing
    p_bus.resp = 1'b1;
    #1;
    chk("idle_resp", 256'({i_bus.resp, d_bus.resp}), 256'(0));
    tick();
    p_bus.resp = 1'b0;
    chk("idle_resp_strobes", 256'({p_bus.read, p_bus.write}), 256'(0));

    // Normal service after the abort
    dw            = rnd256();
    d_bus.write   = 1'b1;
    d_bus.address = 32'h2000;
    d_bus.wdata   = dw;
    sb.push_back(mk_exp(1'b1, 1'b0, 1'b1, 32'h2000, dw));
    tick();
    serve(2, 1'b0);
    tick();

    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
